pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Instruction-fetch front end of the RISC-V core. Holds the program counter and issues word fetches to instruction memory over a req/gnt/rvalid handshake. Presents each fetched instruction with its PC and PC+4 to decode over a valid/ready handshake. It feeds the 32-bit adder stage (PC + 4) and consumes its sum as the next sequential PC. Execute redirects it on taken branches and jumps.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
PC_INC, 32'd4, sequential increment added to the PC.

Ports:
clk_i  input  1  core clock, rising edge
rst_i  input  1  synchronous reset, active-high
imem_req_o  output  1  fetch request
imem_addr_o  output  32  fetch address (always equals pc_q)
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  read data valid
imem_rdata_i  input  32  instruction word
redirect_i  input  1  taken branch/jump from execute
redirect_pc_i  input  32  redirect target
if_ready_i  input  1  decode can accept
if_valid_o  output  1  instruction valid to decode
if_instr_o  output  32  instruction word
if_pc_o  output  32  PC of if_instr_o
if_pc_plus4_o  output  32  if_pc_o + PC_INC
fault_o  output  1  misaligned fetch target, held while in FAULT

Behaviour:
- One clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values, applied at the first rising edge with rst_i=1:
  - state = IDLE, pc_q = RESET_PC, discard_q = 0.
  - if_valid_o = 0, if_instr_o = 0, if_pc_o = 0, if_pc_plus4_o = 0, fault_o = 0.
  - imem_req_o = 0.
- Reset mid-operation: abandons any outstanding fetch and clears discard_q. A stale rvalid arriving after reset is ignored in IDLE and in REQ.
- Next sequential PC = pc_q + PC_INC, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- States:
  - IDLE: outputs idle; go to REQ next cycle.
  - REQ: imem_req_o = 1. pc_q stays stable until imem_gnt_i. On gnt, go to WAIT.
  - WAIT: on imem_rvalid_i with discard_q = 0:
    - if_instr_o <= imem_rdata_i, if_pc_o <= pc_q, if_pc_plus4_o <= pc_q + PC_INC.
    - pc_q <= pc_q + PC_INC.
    - Go to OUT.
  - WAIT: on rvalid with discard_q = 1: drop the data, clear discard_q, go to REQ.
  - OUT: if_valid_o = 1, outputs held stable. On if_valid_o && if_ready_i, go to REQ.
  - FAULT: fault_o = 1, imem_req_o = 0, if_valid_o = 0.
- Only one fetch outstanding at a time.
- Minimum latency: gnt in the first REQ cycle, rvalid one cycle later, if_valid_o one cycle after rvalid. Throughput is one instruction per 3 cycles.
- Redirect has priority over everything except reset. Effect depends on state:
  - REQ, no gnt: pc_q <= redirect_pc_i, stay in REQ.
  - REQ with gnt the same cycle: pc_q <= target, discard_q <= 1, go to WAIT.
  - WAIT, no rvalid: pc_q <= target, discard_q <= 1.
  - WAIT with rvalid the same cycle: drop the data, pc_q <= target, go to REQ.
  - OUT: the current instruction is consumed if if_ready_i=1, otherwise flushed. if_valid_o = 0 next cycle, pc_q <= target, go to REQ.
  - IDLE: pc_q <= target, go to REQ.
- Misaligned target (redirect_pc_i[1:0] != 0):
  - pc_q <= target, go to FAULT.
  - If a fetch is outstanding, discard_q <= 1 so its later rvalid is dropped.
- In FAULT, an rvalid clears discard_q. FAULT exits only on reset or an aligned redirect:
  - to WAIT if discard_q is still set, else to REQ.
  - pc_q <= target, fault_o deasserts next cycle.
- RESET_PC is required to be word-aligned. A misaligned RESET_PC is not checked.

Test Plan:
- Reset release, RESET_PC=0, gnt=1 same cycle, rvalid next cycle with 32'h0000_0013:
  - if_valid_o=1, if_instr_o=32'h13, if_pc_o=0, if_pc_plus4_o=4.
  - Next request address = 32'h0000_0004.
- Backpressure: if_ready_i=0 for 5 cycles in OUT -> if_valid_o, if_instr_o and if_pc_o hold constant, imem_req_o stays 0; first ready cycle -> REQ at pc 4.
- Redirect to 32'h0000_2000 while in WAIT:
  - Old rvalid data 32'hDEAD_BEEF is dropped, never reaches decode.
  - Next request address = 32'h0000_2000, delivered if_pc_o = 32'h2000, if_pc_plus4_o = 32'h2004.
- Redirect to 32'hFFFF_FFFC: fetch returns data -> if_pc_plus4_o = 32'h0000_0000, next request address = 32'h0000_0000 (wrap).
- Redirect to 32'h0000_1002:
  - fault_o=1, imem_req_o=0, if_valid_o=0 indefinitely.
  - Aligned redirect to 32'h0000_1000 -> fault_o=0 next cycle, request at 32'h1000.
- rst_i=1 asserted in WAIT, then a stale rvalid during IDLE/REQ -> ignored; all outputs read zero; first request address = RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - fetch unit bus: imem handshake, redirect and decode handshake
interface pc_fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_ready_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc_plus4_o;
    logic        fault_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  redirect_i, redirect_pc_i,
        input  if_ready_i,
        output if_valid_o, if_instr_o, if_pc_o, if_pc_plus4_o, fault_o
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output redirect_i, redirect_pc_i,
        output if_ready_i,
        input  if_valid_o, if_instr_o, if_pc_o, if_pc_plus4_o, fault_o
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - instruction fetch front end: PC, single-outstanding imem fetch, decode handoff
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pc_fetch_unit_if.master bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [31:0] instr_q, if_pc_q, if_pc_plus4_q;
    logic        capture;
    logic        misaligned;
    logic [31:0] pc_inc;

    assign pc_inc     = pc_q + PC_INC;
    assign misaligned = bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (bus.redirect_i) begin
                    pc_d    = bus.redirect_pc_i;
                    state_d = misaligned ? FAULT : REQ;
                end
            end
            REQ: begin
                if (bus.redirect_i) begin
                    pc_d = bus.redirect_pc_i;
                    // A grant in the redirect cycle launches a stale fetch; drop its data later.
                    if (bus.imem_gnt_i) discard_d = 1'b1;
                    if (misaligned)          state_d = FAULT;
                    else if (bus.imem_gnt_i) state_d = WAIT;
                    else                     state_d = REQ;
                end else if (bus.imem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.redirect_i) begin
                    pc_d      = bus.redirect_pc_i;
                    discard_d = !bus.imem_rvalid_i;
                    if (misaligned)             state_d = FAULT;
                    else if (bus.imem_rvalid_i) state_d = REQ;
                    else                        state_d = WAIT;
                end else if (bus.imem_rvalid_i) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = REQ;
                    end else begin
                        capture = 1'b1;
                        pc_d    = pc_inc;
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (bus.redirect_i) begin
                    pc_d    = bus.redirect_pc_i;
                    state_d = misaligned ? FAULT : REQ;
                end else if (bus.if_ready_i) begin
                    state_d = REQ;
                end
            end
            FAULT: begin
                if (bus.imem_rvalid_i) discard_d = 1'b0;
                if (bus.redirect_i) begin
                    pc_d = bus.redirect_pc_i;
                    // Still owed a response from before the fault: wait it out before refetching.
                    if (!misaligned)
                        state_d = (discard_q && !bus.imem_rvalid_i) ? WAIT : REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            discard_q     <= 1'b0;
            instr_q       <= 32'h0;
            if_pc_q       <= 32'h0;
            if_pc_plus4_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            if (capture) begin
                instr_q       <= bus.imem_rdata_i;
                if_pc_q       <= pc_q;
                if_pc_plus4_q <= pc_inc;
            end
        end
    end

    assign bus.imem_req_o    = (state_q == REQ);
    assign bus.imem_addr_o   = pc_q;
    assign bus.if_valid_o    = (state_q == OUT);
    assign bus.if_instr_o    = instr_q;
    assign bus.if_pc_o       = if_pc_q;
    assign bus.if_pc_plus4_o = if_pc_plus4_q;
    assign bus.fault_o       = (state_q == FAULT);
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed and randomized bench for pc_fetch_unit against a transaction-level model
module tb_pc_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_unit_if bus();

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_INC(32'd4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: the unit is either just out of reset, waiting on memory, holding an
    // instruction for decode, faulted, or (none of those) asking for a fetch.
    bit          m_starting, m_busy, m_holding, m_faulted, m_discard;
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;

    // Memory environment: at most one response owed, delivered after a random delay.
    bit          e_pending;
    int          e_delay;

    function automatic bit m_req();
        return !m_starting && !m_busy && !m_holding && !m_faulted;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_all();
        chk("req",      {31'b0, bus.imem_req_o}, {31'b0, m_req()});
        chk("addr",     bus.imem_addr_o,         m_pc);
        chk("valid",    {31'b0, bus.if_valid_o}, {31'b0, m_holding});
        chk("fault",    {31'b0, bus.fault_o},    {31'b0, m_faulted});
        chk("instr",    bus.if_instr_o,          m_instr);
        chk("pc",       bus.if_pc_o,             m_ipc);
        chk("pc_plus4", bus.if_pc_plus4_o,       m_ipc4);
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        bit redir, mis, gnt, rv;
        tgt   = bus.redirect_pc_i;
        redir = bus.redirect_i;
        mis   = redir && (tgt % 4 != 0);
        gnt   = bus.imem_gnt_i;
        rv    = bus.imem_rvalid_i;
        if (rst) begin
            m_starting = 1; m_busy = 0; m_holding = 0; m_faulted = 0; m_discard = 0;
            m_pc = 32'h0; m_instr = 0; m_ipc = 0; m_ipc4 = 0;
        end else if (m_starting) begin
            m_starting = 0;
            if (redir) begin m_pc = tgt; m_faulted = mis; end
        end else if (m_faulted) begin
            if (rv) m_discard = 0;
            if (redir) begin
                m_pc = tgt;
                if (!mis) begin m_faulted = 0; m_busy = m_discard; end
            end
        end else if (m_holding) begin
            if (redir) begin m_holding = 0; m_pc = tgt; m_faulted = mis; end
            else if (bus.if_ready_i) m_holding = 0;
        end else if (m_busy) begin
            if (redir) begin
                m_pc = tgt;
                if (rv) begin m_busy = 0; m_discard = 0; end
                else m_discard = 1;
                if (mis) begin m_faulted = 1; m_busy = 0; end
            end else if (rv) begin
                m_busy = 0;
                if (m_discard) m_discard = 0;
                else begin
                    m_instr = bus.imem_rdata_i; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
                    m_pc = m_pc + 32'd4; m_holding = 1;
                end
            end
        end else begin
            if (redir) begin
                m_pc = tgt;
                if (gnt) begin m_busy = 1; m_discard = 1; end
                if (mis) begin m_faulted = 1; m_busy = 0; end
            end else if (gnt) m_busy = 1;
        end
    endtask

    // Inputs are already driven (negedge); advance one clock and compare at the next negedge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        bus.imem_gnt_i = 0; bus.imem_rvalid_i = 0; bus.imem_rdata_i = 0;
        bus.redirect_i = 0; bus.redirect_pc_i = 0;
    endtask

    task automatic env_drive();
        bit was_pending;
        rst = ($urandom_range(0, 199) == 0);
        was_pending = e_pending;
        bus.imem_rvalid_i = 0;
        bus.imem_rdata_i  = $urandom;
        if (e_pending) begin
            if (e_delay == 0) begin bus.imem_rvalid_i = 1; e_pending = 0; end
            else e_delay--;
        end
        bus.imem_gnt_i = m_req() && !was_pending && ($urandom_range(0, 1) == 1);
        if (bus.imem_gnt_i && !rst) begin
            e_pending = 1;
            e_delay = $urandom_range(0, 2);
        end
        bus.redirect_i = ($urandom_range(0, 11) == 0);
        case ($urandom_range(0, 9))
            0:       bus.redirect_pc_i = 32'hFFFF_FFFC;
            1:       bus.redirect_pc_i = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} | 32'($urandom_range(1, 3));
            default: bus.redirect_pc_i = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        endcase
        bus.if_ready_i = ($urandom_range(0, 2) != 0);
    endtask

    initial begin
        idle_inputs();
        bus.if_ready_i = 0;
        e_pending = 0; e_delay = 0;
        @(negedge clk);

        rst = 1; cycle(); cycle();
        chk("rst_valid", {31'b0, bus.if_valid_o}, 32'h0);
        chk("rst_req",   {31'b0, bus.imem_req_o}, 32'h0);
        chk("rst_fault", {31'b0, bus.fault_o},    32'h0);
        chk("rst_instr", bus.if_instr_o, 32'h0);
        rst = 0; cycle();
        chk("first_addr", bus.imem_addr_o, 32'h0);

        bus.imem_gnt_i = 1; cycle();
        bus.imem_gnt_i = 0; bus.imem_rvalid_i = 1; bus.imem_rdata_i = 32'h0000_0013; cycle();
        bus.imem_rvalid_i = 0;
        chk("d1_valid", {31'b0, bus.if_valid_o}, 32'h1);
        chk("d1_instr", bus.if_instr_o, 32'h13);
        chk("d1_pc",    bus.if_pc_o, 32'h0);
        chk("d1_pc4",   bus.if_pc_plus4_o, 32'h4);
        chk("model_pc4_pin", m_ipc4, 32'h4);

        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_valid", {31'b0, bus.if_valid_o}, 32'h1);
            chk("bp_instr", bus.if_instr_o, 32'h13);
            chk("bp_req",   {31'b0, bus.imem_req_o}, 32'h0);
        end
        bus.if_ready_i = 1; cycle();
        chk("bp_next_addr", bus.imem_addr_o, 32'h4);

        bus.imem_gnt_i = 1; cycle();
        bus.imem_gnt_i = 0; bus.redirect_i = 1; bus.redirect_pc_i = 32'h0000_2000; cycle();
        bus.redirect_i = 0; bus.imem_rvalid_i = 1; bus.imem_rdata_i = 32'hDEAD_BEEF; cycle();
        bus.imem_rvalid_i = 0;
        chk("rd_drop_valid", {31'b0, bus.if_valid_o}, 32'h0);
        chk("rd_addr", bus.imem_addr_o, 32'h2000);
        bus.imem_gnt_i = 1; cycle();
        bus.imem_gnt_i = 0; bus.imem_rvalid_i = 1; bus.imem_rdata_i = 32'h0000_0093; cycle();
        bus.imem_rvalid_i = 0;
        chk("rd_instr", bus.if_instr_o, 32'h93);
        chk("rd_pc",    bus.if_pc_o, 32'h2000);
        chk("rd_pc4",   bus.if_pc_plus4_o, 32'h2004);

        bus.redirect_i = 1; bus.redirect_pc_i = 32'hFFFF_FFFC; cycle();
        bus.redirect_i = 0;
        chk("wrap_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
        bus.imem_gnt_i = 1; cycle();
        bus.imem_gnt_i = 0; bus.imem_rvalid_i = 1; bus.imem_rdata_i = 32'h0000_0033; cycle();
        bus.imem_rvalid_i = 0;
        chk("wrap_pc",  bus.if_pc_o, 32'hFFFF_FFFC);
        chk("wrap_pc4", bus.if_pc_plus4_o, 32'h0);
        cycle();
        chk("wrap_next", bus.imem_addr_o, 32'h0);

        bus.redirect_i = 1; bus.redirect_pc_i = 32'h0000_1002; cycle();
        bus.redirect_i = 0;
        for (int i = 0; i < 3; i++) begin
            chk("flt_fault", {31'b0, bus.fault_o},    32'h1);
            chk("flt_req",   {31'b0, bus.imem_req_o}, 32'h0);
            chk("flt_valid", {31'b0, bus.if_valid_o}, 32'h0);
            cycle();
        end
        bus.redirect_i = 1; bus.redirect_pc_i = 32'h0000_1000; cycle();
        bus.redirect_i = 0;
        chk("flt_exit_fault", {31'b0, bus.fault_o}, 32'h0);
        chk("flt_exit_req",   {31'b0, bus.imem_req_o}, 32'h1);
        chk("flt_exit_addr",  bus.imem_addr_o, 32'h1000);

        bus.imem_gnt_i = 1; cycle();
        bus.imem_gnt_i = 0; rst = 1; cycle();
        rst = 0; bus.imem_rvalid_i = 1; bus.imem_rdata_i = 32'hBAD0_BAD0; cycle();
        chk("mrst_addr",  bus.imem_addr_o, 32'h0);
        chk("mrst_req",   {31'b0, bus.imem_req_o}, 32'h1);
        chk("mrst_instr", bus.if_instr_o, 32'h0);
        chk("mrst_pc",    bus.if_pc_o, 32'h0);
        chk("mrst_pc4",   bus.if_pc_plus4_o, 32'h0);
        cycle();
        chk("mrst_stale_valid", {31'b0, bus.if_valid_o}, 32'h0);
        bus.imem_rvalid_i = 0;

        for (int i = 0; i < 4000; i++) begin
            env_drive();
            cycle();
        end
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
